// File: rtl/imem_loader.sv
// Instruction RAM loader: packs a little-endian byte stream into 32-bit words and
// writes them to consecutive RAM addresses from 0, holding the core for the whole load.
module imem_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W:0] CAP     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state;
    logic [1:0]      byte_cnt;
    logic [ADDR_W:0] word_cnt;
    logic [ADDR_W:0] n_words;
    logic [23:0]     word_lo;
    logic [ADDR_W:0] n_clamp;

    assign n_clamp = (num_words > CAP) ? CAP : num_words;

    // Outputs are registered: each transition sets the outputs of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            byte_cnt <= '0;
            word_cnt <= '0;
            n_words  <= '0;
            word_lo  <= '0;
            in_ready <= 1'b0;
            ram_we   <= 1'b0;
            ram_a    <= '0;
            ram_d    <= '0;
            cpu_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        n_words  <= n_clamp;
                        if (n_clamp == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_RECV;
                            in_ready <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    // abort wins over completing a word: the partial word is dropped
                    if (abort) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else if (in_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_lo[7:0]   <= in_data;
                            2'd1: word_lo[15:8]  <= in_data;
                            2'd2: word_lo[23:16] <= in_data;
                            2'd3: begin
                                state    <= S_WRITE;
                                in_ready <= 1'b0;
                                ram_we   <= 1'b1;
                                ram_a    <= word_cnt[ADDR_W-1:0];
                                ram_d    <= {in_data, word_lo};
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    word_cnt <= word_cnt + CNT_ONE;
                    byte_cnt <= '0;
                    if (abort) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        cpu_hold <= 1'b0;
                    end else if (word_cnt + CNT_ONE == n_words) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_RECV;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected RAM contents come from the byte list
// packed little-endian, compared against a log of every observed ram_we cycle.
module tb_imem_loader;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_words = '0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = '0;
    logic              in_ready, ram_we, cpu_hold, busy, done;
    logic [ADDR_W-1:0] ram_a;
    logic [DATA_W-1:0] ram_d;

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_words(num_words), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .ram_we(ram_we),
        .ram_a(ram_a), .ram_d(ram_d), .cpu_hold(cpu_hold), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0]  byte_q[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    int done_cnt = 0;
    int rdy_in_we = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_we) begin
                wr_a.push_back(32'(ram_a));
                wr_d.push_back(ram_d);
                if (in_ready) rdy_in_we++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_a.delete(); wr_d.delete(); done_cnt = 0; rdy_in_we = 0;
    endtask

    task automatic do_start(input int n);
        start = 1'b1; num_words = (ADDR_W+1)'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int t = 0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        in_valid = 1'b1; in_data = b;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) chk("ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (!done && t < 2000) begin @(negedge clk); t++; end
        chk(tag, 64'(done), 1);
    endtask

    // Reference: word i is bytes 4i..4i+3 with the first byte least significant.
    task automatic check_writes(input string tag, input int nexp);
        chk({tag, "_nwr"}, 64'(wr_a.size()), 64'(nexp));
        for (int i = 0; i < nexp && i < wr_a.size(); i++) begin
            logic [31:0] w = 0;
            for (int k = 0; k < 4; k++) w = w + (32'(byte_q[4*i+k]) << (8*k));
            chk({tag, "_a"}, 64'(wr_a[i]), 64'(i));
            chk({tag, "_d"}, 64'(wr_d[i]), 64'(w));
        end
    endtask

    task automatic fill_random(input int nbytes);
        byte_q.delete();
        for (int i = 0; i < nbytes; i++) byte_q.push_back(8'($urandom));
    endtask

    initial begin
        @(negedge clk);
        chk("rst_outs", {in_ready, ram_we, cpu_hold, busy, done, 32'(ram_a), ram_d}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single word, exact latency
        clear_log();
        byte_q.delete();
        byte_q.push_back(8'h13); byte_q.push_back(8'h00);
        byte_q.push_back(8'h01); byte_q.push_back(8'h20);
        do_start(1);
        chk("t1_busy", 64'(busy), 1);
        for (int i = 0; i < 4; i++) send_byte(byte_q[i], 0);
        chk("t1_we", 64'(ram_we), 1);
        chk("t1_rdy_we", 64'(in_ready), 0);
        @(negedge clk);
        chk("t1_done", 64'(done), 1);
        chk("t1_hold_done", 64'(cpu_hold), 1);
        @(negedge clk);
        chk("t1_hold_off", {cpu_hold, busy, done}, 0);
        check_writes("t1", 1);

        // 2: three words with random gaps
        clear_log();
        fill_random(12);
        do_start(3);
        for (int i = 0; i < 12; i++) send_byte(byte_q[i], 3);
        wait_done("t2_done");
        repeat (2) @(negedge clk);
        check_writes("t2", 3);
        chk("t2_done_cnt", 64'(done_cnt), 1);
        chk("t2_rdy_in_we", 64'(rdy_in_we), 0);

        // 3a: zero words
        clear_log();
        do_start(0);
        chk("t3_busy", {busy, done, cpu_hold}, 3'b111);
        @(negedge clk);
        chk("t3_idle", 64'(busy), 0);
        chk("t3_nwr", 64'(wr_a.size()), 0);
        chk("t3_done_cnt", 64'(done_cnt), 1);

        // 3b: 100 clamps to 64
        clear_log();
        fill_random(256);
        do_start(100);
        for (int i = 0; i < 256; i++) send_byte(byte_q[i], 0);
        wait_done("t3b_done");
        repeat (2) @(negedge clk);
        chk("t3b_busy", 64'(busy), 0);
        check_writes("t3b", 64);

        // 4: abort mid-word 1
        clear_log();
        fill_random(6);
        do_start(3);
        for (int i = 0; i < 6; i++) send_byte(byte_q[i], 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_idle", {busy, in_ready, cpu_hold}, 0);
        repeat (3) @(negedge clk);
        check_writes("t4", 1);
        chk("t4_no_done", 64'(done_cnt), 0);
        clear_log();
        fill_random(4);
        do_start(1);
        for (int i = 0; i < 4; i++) send_byte(byte_q[i], 2);
        wait_done("t4b_done");
        @(negedge clk);
        check_writes("t4b", 1);

        // 5: async reset mid-RECV, then start while busy is ignored
        clear_log();
        fill_random(8);
        do_start(2);
        send_byte(byte_q[0], 0);
        send_byte(byte_q[1], 0);
        #2 rst = 1'b1;
        #1 chk("t5_async", {in_ready, ram_we, cpu_hold, busy, done, 32'(ram_a), ram_d}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        do_start(2);
        for (int i = 0; i < 8; i++) begin
            send_byte(byte_q[i], 1);
            if (i == 1 || i == 5) do_start(5);
        end
        wait_done("t5_done");
        repeat (2) @(negedge clk);
        check_writes("t5", 2);
        chk("t5_done_cnt", 64'(done_cnt), 1);
        chk("t5_idle", 64'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
